tdm_demux_1to4: RTL and testbench

TDM_DEMUX_1TO4 -- requirements
Module: tdm_demux_1to4

---
 rtl/tdm_pkg.sv | 14 +
 rtl/tdm_slot_counter.sv | 38 +++
 rtl/tdm_demux_1to4.sv | 133 +++++++++++++
 tb/tb_tdm_demux_1to4.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/tdm_pkg.sv
// Shared TDM framing constants and FSM state encoding for the mux and demux sides.
package tdm_pkg;

  localparam int unsigned NUM_CH = 4;
  localparam int unsigned SLOT_W = 2;

  localparam logic [SLOT_W-1:0] LastSlot = SLOT_W'(NUM_CH - 1);

  typedef enum logic [0:0] {
    StHunt   = 1'b0,
    StLocked = 1'b1
  } tdm_state_e;

endpackage

// File: rtl/tdm_slot_counter.sv
// Slot index counter: synchronous clear, load-to-1 and increment with natural wrap at 3.
module tdm_slot_counter
  import tdm_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              en_i,
  input  logic              clr_i,
  input  logic              load_one_i,
  output logic [SLOT_W-1:0] cnt_o
);

  logic [SLOT_W-1:0] cnt_d, cnt_q;

  // Next count: clear beats load, load beats increment.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (load_one_i) begin
      cnt_d = SLOT_W'(1);
    end else if (en_i) begin
      cnt_d = cnt_q + SLOT_W'(1);
    end
  end

  // Count register with synchronous active-high reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/tdm_demux_1to4.sv
// 1-to-4 TDM demultiplexer: locks to frame_sync, collects slots 0..2 in a shadow
// register and publishes all four channels together on the slot-3 sample.
module tdm_demux_1to4
  import tdm_pkg::*;
#(
  parameter int unsigned DATA_W = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [DATA_W-1:0] din,
  input  logic              frame_sync,
  output logic [DATA_W-1:0] y0,
  output logic [DATA_W-1:0] y1,
  output logic [DATA_W-1:0] y2,
  output logic [DATA_W-1:0] y3,
  output logic [SLOT_W-1:0] sel,
  output logic              locked,
  output logic              frame_valid,
  output logic              sync_err
);

  tdm_state_e state_d, state_q;

  logic [DATA_W-1:0] shadow_d [NUM_CH-1];
  logic [DATA_W-1:0] shadow_q [NUM_CH-1];
  logic [DATA_W-1:0] y0_d, y0_q, y1_d, y1_q, y2_d, y2_q, y3_d, y3_q;
  logic              locked_d, locked_q;
  logic              frame_valid_d, frame_valid_q;
  logic              sync_err_d, sync_err_q;

  logic              cnt_clr, cnt_load, cnt_inc;
  logic [SLOT_W-1:0] sel_q;

  tdm_slot_counter u_slot_counter (
    .clk_i      (clk),
    .rst_i      (rst),
    .en_i       (cnt_inc),
    .clr_i      (cnt_clr),
    .load_one_i (cnt_load),
    .cnt_o      (sel_q)
  );

  // Framing FSM, slot capture and frame publication; everything holds when en=0.
  always_comb begin
    state_d       = state_q;
    shadow_d      = shadow_q;
    y0_d          = y0_q;
    y1_d          = y1_q;
    y2_d          = y2_q;
    y3_d          = y3_q;
    frame_valid_d = 1'b0;
    sync_err_d    = 1'b0;
    cnt_clr       = 1'b0;
    cnt_load      = 1'b0;
    cnt_inc       = 1'b0;

    if (en) begin
      unique case (state_q)
        StHunt: begin
          if (frame_sync) begin
            shadow_d[0] = din;
            cnt_load    = 1'b1;
            state_d     = StLocked;
          end
        end
        StLocked: begin
          if (frame_sync) begin
            // Normal frame start at slot 0; anywhere else the partial frame is dropped.
            shadow_d[0] = din;
            cnt_load    = 1'b1;
            sync_err_d  = (sel_q != '0);
          end else if (sel_q == '0) begin
            state_d    = StHunt;
            cnt_clr    = 1'b1;
            sync_err_d = 1'b1;
          end else if (sel_q == LastSlot) begin
            y0_d          = shadow_q[0];
            y1_d          = shadow_q[1];
            y2_d          = shadow_q[2];
            y3_d          = din;
            frame_valid_d = 1'b1;
            cnt_inc       = 1'b1;
          end else begin
            case (sel_q)
              2'd1:    shadow_d[1] = din;
              default: shadow_d[2] = din;
            endcase
            cnt_inc = 1'b1;
          end
        end
        default: state_d = StHunt;
      endcase
    end

    locked_d = (state_d == StLocked);
  end

  // State, shadow and output registers with synchronous active-high reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= StHunt;
      shadow_q      <= '{default: '0};
      y0_q          <= '0;
      y1_q          <= '0;
      y2_q          <= '0;
      y3_q          <= '0;
      locked_q      <= 1'b0;
      frame_valid_q <= 1'b0;
      sync_err_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      shadow_q      <= shadow_d;
      y0_q          <= y0_d;
      y1_q          <= y1_d;
      y2_q          <= y2_d;
      y3_q          <= y3_d;
      locked_q      <= locked_d;
      frame_valid_q <= frame_valid_d;
      sync_err_q    <= sync_err_d;
    end
  end

  assign y0          = y0_q;
  assign y1          = y1_q;
  assign y2          = y2_q;
  assign y3          = y3_q;
  assign sel         = sel_q;
  assign locked      = locked_q;
  assign frame_valid = frame_valid_q;
  assign sync_err    = sync_err_q;

endmodule

// File: tb/tb_tdm_demux_1to4.sv
// Table-driven bench for tdm_demux_1to4 with a frame scoreboard on frame_valid.
module tb_tdm_demux_1to4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b0;
  logic       din = 1'b0;
  logic       frame_sync = 1'b0;
  logic       y0, y1, y2, y3;
  logic [1:0] sel;
  logic       locked, frame_valid, sync_err;

  int checks = 0;
  int errors = 0;
  int fv_seen = 0;

  // y packed as {y0, y1, y2, y3} so a literal reads in slot order.
  logic [3:0] sb_q[$];

  typedef struct {
    logic       rst, en, din, fs;
    logic [1:0] sel;
    logic       lk, fv, se;
    logic [3:0] y;
  } vec_t;

  vec_t vecs[$];

  tdm_demux_1to4 #(.DATA_W(1)) dut (
    .clk         (clk),
    .rst         (rst),
    .en          (en),
    .din         (din),
    .frame_sync  (frame_sync),
    .y0          (y0),
    .y1          (y1),
    .y2          (y2),
    .y3          (y3),
    .sel         (sel),
    .locked      (locked),
    .frame_valid (frame_valid),
    .sync_err    (sync_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int step, input logic [3:0] act,
                       input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s step %0d: got %b expected %b", name, step, act, exp);
    end
  endtask

  task automatic add(input logic r, e, d, f, input logic [1:0] s, input logic lk, fv, se,
                     input logic [3:0] y);
    vec_t v;
    v.rst = r; v.en = e; v.din = d; v.fs = f;
    v.sel = s; v.lk = lk; v.fv = fv; v.se = se; v.y = y;
    vecs.push_back(v);
  endtask

  // Scoreboard: every frame_valid pulse must match the oldest expected frame.
  always @(posedge clk) begin
    logic [3:0] exp_y;
    #1;
    if (frame_valid === 1'b1) begin
      fv_seen++;
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_unexpected_frame: got y=%b expected no frame", {y0, y1, y2, y3});
      end else begin
        exp_y = sb_q.pop_front();
        check("sb_frame", fv_seen, {y0, y1, y2, y3}, exp_y);
      end
    end
  end

  initial begin
    int exp_frames = 0;

    //  rst en din fs   sel  lk fv se  y0..y3
    // Reset for two cycles (second one with active inputs), then idle and hunt.
    add(1, 0, 0, 0, 2'd0, 0, 0, 0, 4'b0000);
    add(1, 1, 1, 1, 2'd0, 0, 0, 0, 4'b0000);
    add(0, 0, 0, 0, 2'd0, 0, 0, 0, 4'b0000);
    add(0, 1, 1, 0, 2'd0, 0, 0, 0, 4'b0000);
    // Frame 1,0,1,1 with continuous en.
    add(0, 1, 1, 1, 2'd1, 1, 0, 0, 4'b0000);
    add(0, 1, 0, 0, 2'd2, 1, 0, 0, 4'b0000);
    add(0, 1, 1, 0, 2'd3, 1, 0, 0, 4'b0000);
    add(0, 1, 1, 0, 2'd0, 1, 1, 0, 4'b1011);
    // Back-to-back 1,0,0,0 then 0,1,1,0 with en toggling; en=0 cycles carry junk.
    add(0, 1, 1, 1, 2'd1, 1, 0, 0, 4'b1011);
    add(0, 0, 0, 1, 2'd1, 1, 0, 0, 4'b1011);
    add(0, 1, 0, 0, 2'd2, 1, 0, 0, 4'b1011);
    add(0, 0, 1, 0, 2'd2, 1, 0, 0, 4'b1011);
    add(0, 1, 0, 0, 2'd3, 1, 0, 0, 4'b1011);
    add(0, 0, 1, 1, 2'd3, 1, 0, 0, 4'b1011);
    add(0, 1, 0, 0, 2'd0, 1, 1, 0, 4'b1000);
    add(0, 0, 1, 0, 2'd0, 1, 0, 0, 4'b1000);
    add(0, 1, 0, 1, 2'd1, 1, 0, 0, 4'b1000);
    add(0, 0, 0, 0, 2'd1, 1, 0, 0, 4'b1000);
    add(0, 1, 1, 0, 2'd2, 1, 0, 0, 4'b1000);
    add(0, 0, 0, 0, 2'd2, 1, 0, 0, 4'b1000);
    add(0, 1, 1, 0, 2'd3, 1, 0, 0, 4'b1000);
    add(0, 0, 1, 0, 2'd3, 1, 0, 0, 4'b1000);
    add(0, 1, 0, 0, 2'd0, 1, 1, 0, 4'b0110);
    add(0, 0, 1, 0, 2'd0, 1, 0, 0, 4'b0110);
    // Early sync at sel=2, then new frame 0,0,1,1.
    add(0, 1, 1, 1, 2'd1, 1, 0, 0, 4'b0110);
    add(0, 1, 1, 0, 2'd2, 1, 0, 0, 4'b0110);
    add(0, 1, 0, 1, 2'd1, 1, 0, 1, 4'b0110);
    add(0, 1, 0, 0, 2'd2, 1, 0, 0, 4'b0110);
    add(0, 1, 1, 0, 2'd3, 1, 0, 0, 4'b0110);
    add(0, 1, 1, 0, 2'd0, 1, 1, 0, 4'b0011);
    // Missing sync at sel=0: drop lock, keep y, ignore din while hunting.
    add(0, 1, 1, 0, 2'd0, 0, 0, 1, 4'b0011);
    add(0, 1, 1, 0, 2'd0, 0, 0, 0, 4'b0011);
    add(0, 1, 0, 0, 2'd0, 0, 0, 0, 4'b0011);
    // Reset at sel=2 clears everything with no frame pulse.
    add(0, 1, 1, 1, 2'd1, 1, 0, 0, 4'b0011);
    add(0, 1, 1, 0, 2'd2, 1, 0, 0, 4'b0011);
    add(1, 1, 1, 0, 2'd0, 0, 0, 0, 4'b0000);
    add(1, 1, 1, 0, 2'd0, 0, 0, 0, 4'b0000);
    add(0, 1, 1, 0, 2'd0, 0, 0, 0, 4'b0000);
    // Early sync at sel=3 must not publish; restarted frame 1,1,1,0 completes.
    add(0, 1, 1, 1, 2'd1, 1, 0, 0, 4'b0000);
    add(0, 1, 0, 0, 2'd2, 1, 0, 0, 4'b0000);
    add(0, 1, 0, 0, 2'd3, 1, 0, 0, 4'b0000);
    add(0, 1, 1, 1, 2'd1, 1, 0, 1, 4'b0000);
    add(0, 1, 1, 0, 2'd2, 1, 0, 0, 4'b0000);
    add(0, 1, 1, 0, 2'd3, 1, 0, 0, 4'b0000);
    add(0, 1, 0, 0, 2'd0, 1, 1, 0, 4'b1110);
    add(0, 0, 0, 0, 2'd0, 1, 0, 0, 4'b1110);

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      rst        = vecs[i].rst;
      en         = vecs[i].en;
      din        = vecs[i].din;
      frame_sync = vecs[i].fs;
      if (vecs[i].fv) begin
        sb_q.push_back(vecs[i].y);
        exp_frames++;
      end
      @(posedge clk);
      #1;
      check("sel", i, {2'b00, sel}, {2'b00, vecs[i].sel});
      check("locked", i, {3'b000, locked}, {3'b000, vecs[i].lk});
      check("frame_valid", i, {3'b000, frame_valid}, {3'b000, vecs[i].fv});
      check("sync_err", i, {3'b000, sync_err}, {3'b000, vecs[i].se});
      check("y", i, {y0, y1, y2, y3}, vecs[i].y);
    end

    @(negedge clk);
    en = 1'b0;
    repeat (2) @(posedge clk);
    #2;

    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL sb_drained: got %0d pending frames expected 0", sb_q.size());
    end
    checks++;
    if (fv_seen != exp_frames) begin
      errors++;
      $display("FAIL frame_count: got %0d pulses expected %0d", fv_seen, exp_frames);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
